// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: default widths and FSM state encoding.
package product_accumulator_pkg;

  localparam int unsigned PwDefault   = 8;
  localparam int unsigned AwDefault   = 16;
  localparam int unsigned LenWDefault = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StAcc  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned Width-bit adder that clamps to all-ones on carry-out and flags the clamp.
module sat_adder #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o,
  output logic             ovf_o
);

  logic [Width:0] sum_wide;

  assign sum_wide = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o    = sum_wide[Width];
  assign sum_o    = sum_wide[Width] ? {Width{1'b1}} : sum_wide[Width-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a run of len unsigned products into a saturating sum, one result per run,
// with valid/ready handshakes on both sides.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PW    = PwDefault,
  parameter int unsigned AW    = AwDefault,
  parameter int unsigned LEN_W = LenWDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic [PW-1:0]    in_prod_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [AW-1:0]    out_sum_o,
  output logic             out_ovf_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [AW-1:0]    prod_ext;
  logic [AW-1:0]    add_sum;
  logic             add_ovf;
  logic             xfer;

  assign prod_ext = AW'(in_prod_i);
  assign xfer     = in_valid_i && (state_q == StAcc);

  sat_adder #(
    .Width(AW)
  ) u_sat_adder (
    .a_i  (acc_q),
    .b_i  (prod_ext),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = len_i;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = (len_i == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (xfer) begin
          acc_d = add_sum;
          // Sticky: once clamped the sum stays all-ones, since products are never negative.
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StAcc);
  assign out_valid_o = (state_q == StDone);
  assign out_sum_o   = acc_q;
  assign out_ovf_o   = ovf_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a 16-bit and an 8-bit accumulator, checked against a plain-sum model.
module tb_product_accumulator;

  typedef struct packed {
    logic [15:0] sum;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start     [2];
  logic [3:0]  len       [2];
  logic        in_valid  [2];
  logic [7:0]  in_prod   [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ovf   [2];
  logic        out_ready [2];
  logic        busy      [2];
  logic [15:0] sum16;
  logic [7:0]  sum8;

  int   total = 0;
  int   bad   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  logic [7:0] stim_q[$];

  product_accumulator #(.PW(8), .AW(16), .LEN_W(4)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .len_i(len[0]),
    .in_valid_i(in_valid[0]), .in_prod_i(in_prod[0]), .in_ready_o(in_ready[0]),
    .out_valid_o(out_valid[0]), .out_sum_o(sum16), .out_ovf_o(out_ovf[0]),
    .out_ready_i(out_ready[0]), .busy_o(busy[0])
  );

  product_accumulator #(.PW(8), .AW(8), .LEN_W(4)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .len_i(len[1]),
    .in_valid_i(in_valid[1]), .in_prod_i(in_prod[1]), .in_ready_o(in_ready[1]),
    .out_valid_o(out_valid[1]), .out_sum_o(sum8), .out_ovf_o(out_ovf[1]),
    .out_ready_i(out_ready[1]), .busy_o(busy[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: while a result is presented it must equal the queue head; pop on handshake.
  task automatic mon(input int d);
    exp_t e;
    logic [15:0] s;
    s = (d == 0) ? sum16 : {8'h00, sum8};
    if (out_valid[d]) begin
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL unexpected_result dut%0d: got sum=%0d ovf=%0d expected none", d, s,
                 out_ovf[d]);
      end else begin
        e = (d == 0) ? sb0[0] : sb1[0];
        chk($sformatf("out_sum dut%0d", d), int'(s), int'(e.sum));
        chk($sformatf("out_ovf dut%0d", d), int'(out_ovf[d]), int'(e.ovf));
        if (out_ready[d]) begin
          if (d == 0) void'(sb0.pop_front());
          else        void'(sb1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Reference: the run's result is the plain sum of its products, clamped to the width.
  task automatic push_expected(input int d);
    longint tot;
    longint maxv;
    exp_t   e;
    tot  = 0;
    maxv = (d == 0) ? 65535 : 255;
    foreach (stim_q[i]) tot += stim_q[i];
    e.sum = (tot > maxv) ? 16'(maxv) : 16'(tot);
    e.ovf = (tot > maxv);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic feed(input int d, input int idx, input int bubble_max);
    int k;
    repeat ($urandom_range(0, bubble_max)) begin
      in_valid[d] = 1'b0;
      in_prod[d]  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b1;
    in_prod[d]  = stim_q[idx];
    k = 0;
    while (!in_ready[d] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 20) chk($sformatf("in_ready timeout dut%0d", d), 0, 1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_prod[d]  = 8'($urandom);
  endtask

  task automatic run(input int d, input int bubble_max, input int hold, input bit start_in_done,
                     input string tag);
    push_expected(d);
    start[d] = 1'b1;
    len[d]   = 4'(stim_q.size());
    @(posedge clk); #1;
    start[d] = 1'b0;
    len[d]   = 4'($urandom);
    for (int i = 0; i < stim_q.size(); i++) feed(d, i, bubble_max);
    chk({tag, " out_valid latency"}, int'(out_valid[d]), 1);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (start_in_done) start[d] = 1'b1;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    start[d]     = 1'b0;
    chk({tag, " busy after handoff"}, int'(busy[d]), 0);
    chk({tag, " out_valid after handoff"}, int'(out_valid[d]), 0);
    if (start_in_done) begin
      @(posedge clk); #1;
      chk({tag, " start in DONE ignored"}, int'(busy[d]), 0);
    end
  endtask

  task automatic set_prods(input int a[$], input int b[$]);
    stim_q.delete();
    foreach (a[i]) stim_q.push_back(8'(a[i] * b[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; len[d] = '0; in_valid[d] = 1'b0; in_prod[d] = '0; out_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid[0]), 0);
    chk("reset in_ready", int'(in_ready[0]), 0);
    chk("reset busy", int'(busy[0]), 0);
    chk("reset out_sum", int'(sum16), 0);
    chk("reset out_ovf", int'(out_ovf[0]), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_prods('{2, 3, 3, 3}, '{2, 3, 4, 5});
    run(0, 0, 0, 1'b0, "len4 back-to-back");
    run(0, 3, 3, 1'b1, "len4 bubbles hold");

    stim_q.delete();
    run(0, 0, 0, 1'b0, "len0");
    set_prods('{0}, '{0});
    run(0, 0, 1, 1'b0, "len1 zero");

    set_prods('{15, 15, 15}, '{15, 15, 15});
    run(1, 1, 2, 1'b0, "aw8 saturate");

    // Abort a run with reset after two of four transfers: no result may appear.
    set_prods('{1, 2, 3, 4}, '{1, 2, 3, 4});
    start[0] = 1'b1; len[0] = 4'd4;
    @(posedge clk); #1;
    start[0] = 1'b0;
    feed(0, 0, 0);
    feed(0, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", int'(busy[0]), 0);
    chk("abort out_valid", int'(out_valid[0]), 0);
    chk("abort in_ready", int'(in_ready[0]), 0);
    set_prods('{1, 3}, '{1, 3});
    run(0, 0, 0, 1'b0, "after abort");

    for (int r = 0; r < 30; r++) begin
      int d;
      d = (r % 3 == 2) ? 1 : 0;
      n = $urandom_range(0, 15);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, 15) * $urandom_range(0, 15)));
      run(d, 2, $urandom_range(0, 3), 1'($urandom), $sformatf("random run %0d", r));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard drained dut0", sb0.size(), 0);
    chk("scoreboard drained dut1", sb1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
